prll_bus_rr_gen: RTL and testbench

PRLL_BUS_RR_GEN -- requirements
Module: prll_bus_rr_gen

---
 rtl/prll_bus_rr_gen.sv | 179 +++++++++++++++++
 tb/tb_prll_bus_rr_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prll_bus_rr_gen.sv
// prll_bus_rr_gen: N-agent shared bus, per-agent in/out FIFOs, round-robin bus arbitration.
// Define PRLL_BUS_BDCST_EN to deliver the BDCST destination to every agent except the source.
module prll_bus_rr_gen #(
  parameter int              N     = 3,
  parameter int              BITS  = 65,
  parameter int              DEPTH = 4,
  parameter int              ID_W  = 3,
  parameter logic [ID_W-1:0] BDCST = {ID_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      push,
  input  logic [N*BITS-1:0] D_push,
  output logic [N-1:0]      full,
  input  logic [N-1:0]      pop,
  output logic [N*BITS-1:0] D_pop,
  output logic [N-1:0]      pndng,
  output logic              drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(N);

  typedef enum logic {IDLE, SEND} state_e;
  typedef logic [BITS-1:0] word_t;

  word_t          in_mem_q  [N][DEPTH];
  word_t          in_mem_d  [N][DEPTH];
  word_t          out_mem_q [N][DEPTH];
  word_t          out_mem_d [N][DEPTH];
  logic [PW-1:0]  in_wr_q [N], in_wr_d [N], in_rd_q [N], in_rd_d [N];
  logic [PW-1:0]  out_wr_q[N], out_wr_d[N], out_rd_q[N], out_rd_d[N];
  logic [CW-1:0]  in_cnt_q[N], in_cnt_d[N], out_cnt_q[N], out_cnt_d[N];

  state_e         state_q, state_d;
  logic [RW-1:0]  rr_q, rr_d, src_q, src_d, grant;
  word_t          word_q, word_d;
  logic           drop_q, drop_d;
  logic           found, space_ok, xfer, in_acc, out_acc;
  logic [N-1:0]   mask, out_full, in_pop_v, out_push_v;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Empty mask means the word has nowhere to go and is dropped.
  function automatic logic [N-1:0] dest_mask(input word_t w, input logic [RW-1:0] s);
    logic [ID_W-1:0] d;
    d = w[BITS-1 -: ID_W];
    if (d == BDCST) begin
`ifdef PRLL_BUS_BDCST_EN
      return ~(N'(1) << s);
`else
      return '0;
`endif
    end
    if (d < ID_W'(N)) return N'(1) << d;
    return '0;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    src_d     = src_q;
    word_d    = word_q;
    drop_d    = 1'b0;
    in_mem_d  = in_mem_q;
    out_mem_d = out_mem_q;
    in_wr_d   = in_wr_q;
    in_rd_d   = in_rd_q;
    in_cnt_d  = in_cnt_q;
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    out_cnt_d = out_cnt_q;
    in_acc    = 1'b0;
    out_acc   = 1'b0;

    for (int i = 0; i < N; i++) out_full[i] = (out_cnt_q[i] == CW'(DEPTH));

    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && in_cnt_q[(int'(rr_q) + k) % N] != '0) begin
        found = 1'b1;
        grant = RW'((int'(rr_q) + k) % N);
      end
    end

    mask       = dest_mask(word_q, src_q);
    space_ok   = ~|(mask & out_full);
    xfer       = (state_q == SEND) && space_ok;
    in_pop_v   = xfer ? (N'(1) << src_q) : '0;
    out_push_v = xfer ? mask : '0;

    case (state_q)
      IDLE: if (found) begin
        state_d = SEND;
        src_d   = grant;
        word_d  = in_mem_q[grant][in_rd_q[grant]];
        drop_d  = (dest_mask(in_mem_q[grant][in_rd_q[grant]], grant) == '0);
      end
      SEND: if (space_ok) begin
        state_d = IDLE;
        rr_d    = src_q;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < N; i++) begin
      // A full in-FIFO still accepts a push when the bus drains it on the same edge.
      in_acc = push[i] && (in_cnt_q[i] != CW'(DEPTH) || in_pop_v[i]);
      if (in_acc) begin
        in_mem_d[i][in_wr_q[i]] = D_push[i*BITS +: BITS];
        in_wr_d[i]              = next_ptr(in_wr_q[i]);
      end
      if (in_pop_v[i]) in_rd_d[i] = next_ptr(in_rd_q[i]);
      in_cnt_d[i] = in_cnt_q[i] + CW'(in_acc) - CW'(in_pop_v[i]);

      out_acc = pop[i] && (out_cnt_q[i] != '0);
      if (out_push_v[i]) begin
        out_mem_d[i][out_wr_q[i]] = word_q;
        out_wr_d[i]               = next_ptr(out_wr_q[i]);
      end
      if (out_acc) out_rd_d[i] = next_ptr(out_rd_q[i]);
      out_cnt_d[i] = out_cnt_q[i] + CW'(out_push_v[i]) - CW'(out_acc);
    end
  end

  always_comb begin
    full  = '0;
    pndng = '0;
    D_pop = '0;
    for (int i = 0; i < N; i++) begin
      full[i]  = (in_cnt_q[i] == CW'(DEPTH));
      pndng[i] = (out_cnt_q[i] != '0);
      D_pop[i*BITS +: BITS] = pndng[i] ? out_mem_q[i][out_rd_q[i]] : '0;
    end
    drop = drop_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= RW'(N - 1);
      src_q   <= '0;
      word_q  <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        in_wr_q[i]   <= '0;
        in_rd_q[i]   <= '0;
        in_cnt_q[i]  <= '0;
        out_wr_q[i]  <= '0;
        out_rd_q[i]  <= '0;
        out_cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      src_q     <= src_d;
      word_q    <= word_d;
      drop_q    <= drop_d;
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // NOTE: storage is not reset; emptiness comes from the counters and D_pop is masked while empty.
  always_ff @(posedge clk) begin
    in_mem_q  <= in_mem_d;
    out_mem_q <= out_mem_d;
  end

endmodule

// File: tb/tb_prll_bus_rr_gen.sv
// Bench for prll_bus_rr_gen: queue-level bus model checked every cycle plus directed literal checks.
module tb_prll_bus_rr_gen;
  localparam int N = 3, BITS = 65, DEPTH = 4, ID_W = 3;
  typedef logic [BITS-1:0] word_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      push = '0;
  logic [N-1:0]      pop = '0;
  logic [N*BITS-1:0] D_push = '0;
  logic [N-1:0]      full, pndng;
  logic [N*BITS-1:0] D_pop;
  logic              drop;

  always #5 clk = ~clk;

  prll_bus_rr_gen #(.N(N), .BITS(BITS), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .full(full),
    .pop(pop), .D_pop(D_pop), .pndng(pndng), .drop(drop)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t mk(input int dest, input longint pay);
    return {3'(dest), 62'(pay)};
  endfunction

  // Set of agents a word must reach; empty set means it is discarded.
  function automatic logic [N-1:0] route(input word_t w, input int src);
    int d;
    d = int'(w[BITS-1 -: ID_W]);
    if (d == 7) begin
`ifdef PRLL_BUS_BDCST_EN
      return ~(N'(1) << src);
`else
      return '0;
`endif
    end
    if (d < N) return N'(1) << d;
    return '0;
  endfunction

  // Model state: FIFOs as queues, the bus as "holding a word for src" or free.
  word_t in_q [N][$];
  word_t out_q[N][$];
  bit    m_valid = 0;
  bit    m_busy, m_drop;
  int    m_rr, m_src;
  word_t m_word;

  always @(posedge clk) begin : model
    logic [N-1:0] m;
    bit deliver, found, busy_n, drop_n, ipop, room;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        in_q[i].delete();
        out_q[i].delete();
      end
      m_busy  = 0;
      m_drop  = 0;
      m_rr    = N - 1;
      m_valid = 1;
    end else begin
      deliver = 0;
      drop_n  = 0;
      busy_n  = m_busy;
      m       = route(m_word, m_src);
      if (m_busy) begin
        room = 1;
        for (int i = 0; i < N; i++) if (m[i] && out_q[i].size() == DEPTH) room = 0;
        if (room) begin
          deliver = 1;
          busy_n  = 0;
        end
      end else begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && in_q[(m_rr + k) % N].size() > 0) begin
            found  = 1;
            m_src  = (m_rr + k) % N;
            m_word = in_q[m_src][0];
            drop_n = (route(m_word, m_src) == '0);
            busy_n = 1;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (pop[i] && out_q[i].size() > 0) void'(out_q[i].pop_front());
        if (deliver && m[i]) out_q[i].push_back(m_word);
        ipop = deliver && (i == m_src);
        room = (in_q[i].size() < DEPTH) || ipop;
        if (ipop) void'(in_q[i].pop_front());
        if (push[i] && room) in_q[i].push_back(D_push[i*BITS +: BITS]);
      end
      if (deliver) m_rr = m_src;
      m_busy = busy_n;
      m_drop = drop_n;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0]      ef, ep;
    logic [N*BITS-1:0] ed;
    if (m_valid) begin
      ed = '0;
      for (int i = 0; i < N; i++) begin
        ef[i] = (in_q[i].size() == DEPTH);
        ep[i] = (out_q[i].size() != 0);
        if (ep[i]) ed[i*BITS +: BITS] = out_q[i][0];
      end
      check("model_full", 256'(full), 256'(ef));
      check("model_pndng", 256'(pndng), 256'(ep));
      check("model_D_pop", 256'(D_pop), 256'(ed));
      check("model_drop", 256'(drop), 256'(m_drop));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    push   = '0;
    pop    = '0;
    reset  = 1'b1;
    tick(1);
    reset  = 1'b0;
  endtask

  function automatic word_t slot(input logic [N*BITS-1:0] v, input int i);
    return v[i*BITS +: BITS];
  endfunction

  initial begin
    word_t w;
    word_t a[3];

    // Reset state
    tick(2);
    check("rst_full", 256'(full), 256'(0));
    check("rst_pndng", 256'(pndng), 256'(0));
    check("rst_drop", 256'(drop), 256'(0));
    check("rst_D_pop", 256'(D_pop), 256'(0));
    reset = 1'b0;

    // Single unicast 0 -> 2, pndng after edge t+2
    w = mk(2, 64'h1234_5678_9abc);
    push[0] = 1'b1;
    D_push[0 +: BITS] = w;
    tick(1);
    push = '0;
    check("uni_t0_pndng", 256'(pndng), 256'(0));
    tick(1);
    check("uni_t1_pndng", 256'(pndng), 256'(0));
    tick(1);
    check("uni_t2_pndng", 256'(pndng), 256'(3'b100));
    check("uni_t2_word", 256'(slot(D_pop, 2)), 256'(w));
    check("uni_t2_drop", 256'(drop), 256'(0));
    pop[2] = 1'b1;
    tick(1);
    pop = '0;
    check("uni_popped", 256'(pndng), 256'(0));

    // Three agents to dest 0 on the same cycle
    do_reset();
    for (int i = 0; i < N; i++) begin
      a[i] = mk(0, 64'h100 + i);
      D_push[i*BITS +: BITS] = a[i];
    end
    push = 3'b111;
    tick(1);
    push = '0;
    tick(2);
    check("rr_first", 256'(slot(D_pop, 0)), 256'(a[0]));
    tick(4);
    pop[0] = 1'b1;
    for (int k = 0; k < N; k++) begin
      check("rr_order", 256'(slot(D_pop, 0)), 256'(a[k]));
      tick(1);
    end
    pop = '0;
    check("rr_drained", 256'(pndng), 256'(0));

    // Self-delivery 1->1 and 2->2
    do_reset();
    D_push[1*BITS +: BITS] = mk(1, 64'h11);
    D_push[2*BITS +: BITS] = mk(2, 64'h22);
    push = 3'b110;
    tick(1);
    push = '0;
    tick(2);
    check("self_first", 256'(pndng), 256'(3'b010));
    tick(2);
    check("self_both", 256'(pndng), 256'(3'b110));

    // Back-pressure: fill out-FIFO 1, agent 2 stalls in SEND
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      push[0] = 1'b1;
      D_push[0 +: BITS] = mk(1, 64'h200 + k);
      tick(1);
    end
    push = '0;
    tick(10);
    check("bp_out1_full", 256'(pndng), 256'(3'b010));
    for (int k = 0; k < DEPTH; k++) begin
      push[2] = 1'b1;
      D_push[2*BITS +: BITS] = mk(1, 64'h300 + k);
      tick(1);
    end
    push = '0;
    tick(6);
    check("bp_in2_full", 256'(full), 256'(3'b100));
    check("bp_head", 256'(slot(D_pop, 1)), 256'(mk(1, 64'h200)));
    tick(3);
    check("bp_held", 256'(full), 256'(3'b100));
    pop[1] = 1'b1;
    tick(1);
    pop = '0;
    check("bp_after_pop", 256'(slot(D_pop, 1)), 256'(mk(1, 64'h201)));
    check("bp_not_yet", 256'(full), 256'(3'b100));
    tick(1);
    check("bp_delivered", 256'(full), 256'(3'b000));

    // Invalid destination 5
    do_reset();
    push[0] = 1'b1;
    D_push[0 +: BITS] = mk(5, 64'h55);
    tick(1);
    push = '0;
    check("inv_pre", 256'(drop), 256'(0));
    tick(1);
    check("inv_pulse", 256'(drop), 256'(1));
    tick(1);
    check("inv_after", 256'(drop), 256'(0));
    check("inv_pndng", 256'(pndng), 256'(0));
    check("inv_full", 256'(full), 256'(0));

    // Broadcast from agent 1
    do_reset();
    w = mk(7, 64'h77);
    push[1] = 1'b1;
    D_push[1*BITS +: BITS] = w;
    tick(1);
    push = '0;
    tick(1);
`ifdef PRLL_BUS_BDCST_EN
    check("bc_drop", 256'(drop), 256'(0));
    tick(1);
    check("bc_pndng", 256'(pndng), 256'(3'b101));
    check("bc_word0", 256'(slot(D_pop, 0)), 256'(w));
    check("bc_word2", 256'(slot(D_pop, 2)), 256'(w));
`else
    check("bc_drop", 256'(drop), 256'(1));
    tick(1);
    check("bc_pndng", 256'(pndng), 256'(0));
`endif

    // Reset while the bus holds a word
    do_reset();
    push[0] = 1'b1;
    D_push[0 +: BITS] = mk(2, 64'hdead);
    tick(1);
    push = '0;
    tick(1);
    reset = 1'b1;
    tick(1);
    check("abort_pndng", 256'(pndng), 256'(0));
    check("abort_D_pop", 256'(D_pop), 256'(0));
    reset = 1'b0;
    tick(5);
    check("abort_never", 256'(pndng), 256'(0));
    check("abort_never_D", 256'(D_pop), 256'(0));

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
